// File: rtl/rca_add_sequencer.sv
// rca_add_sequencer: multi-cycle add/subtract reusing one SLICE-bit ripple-carry slice per cycle
module rca_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic carry_q, carry_d, co_q, co_d, ov_q, ov_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [SLICE-1:0] a_s, b_s;
    logic [SLICE:0] sum;
    logic last;
    always_comb begin
        a_s      = a_q[idx_q*SLICE +: SLICE];
        b_s      = b_q[idx_q*SLICE +: SLICE];
        sum      = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, carry_q};
        last     = idx_q == IW'(N - 1);
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        co_d     = co_q;
        ov_d     = ov_q;
        idx_d    = idx_q;
        if (state_q == IDLE && start) begin
            a_d     = x;
            b_d     = op_sub ? ~y : y;
            carry_d = op_sub;
            idx_d   = '0;
            state_d = EXEC;
        end else if (state_q == EXEC) begin
            result_d[idx_q*SLICE +: SLICE] = sum[SLICE-1:0];
            carry_d = sum[SLICE];
            idx_d   = idx_q + 1'b1;
            if (last) begin
                co_d    = sum[SLICE];
                // carry into the MSB is recovered from the MSB sum bit and its operands
                ov_d    = sum[SLICE] ^ sum[SLICE-1] ^ a_s[SLICE-1] ^ b_s[SLICE-1];
                state_d = DONE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
            idx_q    <= idx_d;
        end
    end
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign result    = result_q;
    assign carry_out = co_q;
    assign overflow  = ov_q;
endmodule
